// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the datapath controller and pc_sequencer.
// The master drives control and LUT programming; the slave returns PC and status.
interface pc_sequencer_if #(
  parameter int PC_W    = 16,
  parameter int IDX_W   = 4,
  parameter int BANK_W  = 1,
  parameter int STACK_D = 4
);
  localparam int KEY_W = IDX_W + BANK_W;
  localparam int DEP_W = $clog2(STACK_D + 1);

  logic             en;
  logic             br_abs;
  logic             br_rel_z;
  logic             br_rel_nz;
  logic             call;
  logic             ret;
  logic             halt;
  logic [KEY_W-1:0] lut_key;
  logic             flag_we;
  logic             alu_zero;
  logic             lut_we;
  logic             lut_rel;
  logic [KEY_W-1:0] lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  pc;
  logic             done;
  logic [DEP_W-1:0] depth;
  logic             err_ovf;
  logic             err_unf;

  modport master (
    output en, br_abs, br_rel_z, br_rel_nz, call, ret, halt, lut_key,
           flag_we, alu_zero, lut_we, lut_rel, lut_waddr, lut_wdata,
    input  pc, done, depth, err_ovf, err_unf
  );

  modport slave (
    input  en, br_abs, br_rel_z, br_rel_nz, call, ret, halt, lut_key,
           flag_we, alu_zero, lut_we, lut_rel, lut_waddr, lut_wdata,
    output pc, done, depth, err_ovf, err_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, writable ABS/REL branch-target LUTs,
// and a hardware return stack resolving ret > call > br_abs > rel-branch > pc+1.
module pc_sequencer #(
  parameter int PC_W    = 16,
  parameter int IDX_W   = 4,
  parameter int BANK_W  = 1,
  parameter int STACK_D = 4
) (
  input  logic          CLK,
  input  logic          reset,
  pc_sequencer_if.slave bus
);
  localparam int KEY_W = IDX_W + BANK_W;
  localparam int LUT_N = 1 << KEY_W;
  localparam int DEP_W = $clog2(STACK_D + 1);

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [DEP_W-1:0] depth_q, depth_d;
  logic             flag_q, flag_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PC_W-1:0]  stack_q   [STACK_D];
  logic [PC_W-1:0]  stack_d   [STACK_D];
  logic [PC_W-1:0]  lut_abs_q [LUT_N];
  logic [PC_W-1:0]  lut_abs_d [LUT_N];
  logic [PC_W-1:0]  lut_rel_q [LUT_N];
  logic [PC_W-1:0]  lut_rel_d [LUT_N];

  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  abs_tgt;
  logic [PC_W-1:0]  rel_tgt;
  logic [PC_W-1:0]  stack_top;
  logic             stack_full;
  logic             stack_empty;

  // Lookups read the pre-edge LUT contents, so a same-cycle write is not visible.
  assign pc_inc      = pc_q + PC_W'(1);
  assign abs_tgt     = lut_abs_q[bus.lut_key];
  assign rel_tgt     = pc_q + lut_rel_q[bus.lut_key];
  assign stack_full  = (depth_q == DEP_W'(STACK_D));
  assign stack_empty = (depth_q == '0);

  // Slot selection by comparison keeps the occupancy counter width independent of the slot index width.
  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < STACK_D; i++) begin
      if (DEP_W'(i + 1) == depth_q) stack_top = stack_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    stack_d   = stack_q;
    flag_d    = bus.flag_we ? bus.alu_zero : flag_q;
    lut_abs_d = lut_abs_q;
    lut_rel_d = lut_rel_q;

    if (bus.lut_we) begin
      if (bus.lut_rel) lut_rel_d[bus.lut_waddr] = bus.lut_wdata;
      else             lut_abs_d[bus.lut_waddr] = bus.lut_wdata;
    end

    if (bus.en && state_q == ST_RUN) begin
      if (bus.halt) begin
        state_d = ST_HALT;
      end else if (bus.ret) begin
        if (stack_empty) begin
          unf_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          pc_d    = stack_top;
          depth_d = depth_q - DEP_W'(1);
        end
      end else if (bus.call) begin
        if (stack_full) begin
          ovf_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          for (int unsigned i = 0; i < STACK_D; i++) begin
            if (DEP_W'(i) == depth_q) stack_d[i] = pc_inc;
          end
          depth_d = depth_q + DEP_W'(1);
          pc_d    = abs_tgt;
        end
      end else if (bus.br_abs) begin
        pc_d = abs_tgt;
      end else if (bus.br_rel_z && flag_q) begin
        pc_d = rel_tgt;
      end else if (bus.br_rel_nz && !flag_q) begin
        pc_d = rel_tgt;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      depth_q <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int unsigned i = 0; i < STACK_D; i++) stack_q[i] <= '0;
      for (int unsigned i = 0; i < LUT_N; i++) begin
        lut_abs_q[i] <= '0;
        lut_rel_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      depth_q   <= depth_d;
      flag_q    <= flag_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      stack_q   <= stack_d;
      lut_abs_q <= lut_abs_d;
      lut_rel_q <= lut_rel_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.done    = (state_q == ST_HALT);
  assign bus.depth   = depth_q;
  assign bus.err_ovf = ovf_q;
  assign bus.err_unf = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed walk-through of the main control-flow cases
// followed by random traffic, all compared against a behavioural model.
module tb_pc_sequencer;
  localparam int PC_W    = 16;
  localparam int IDX_W   = 4;
  localparam int BANK_W  = 1;
  localparam int STACK_D = 4;
  localparam int LUT_N   = 1 << (IDX_W + BANK_W);

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W), .IDX_W(IDX_W), .BANK_W(BANK_W), .STACK_D(STACK_D)) bus ();

  pc_sequencer #(.PC_W(PC_W), .IDX_W(IDX_W), .BANK_W(BANK_W), .STACK_D(STACK_D)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural model state
  logic [15:0] pc_m;
  logic        done_m, flag_m, ovf_m, unf_m;
  logic [15:0] abs_m [LUT_N];
  logic [15:0] rel_m [LUT_N];
  logic [15:0] stk_m [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [15:0] a_rd, r_rd;
    if (reset) begin
      pc_m = 0; done_m = 0; flag_m = 0; ovf_m = 0; unf_m = 0;
      stk_m.delete();
      for (int i = 0; i < LUT_N; i++) begin abs_m[i] = 0; rel_m[i] = 0; end
      return;
    end
    a_rd = abs_m[bus.lut_key];
    r_rd = rel_m[bus.lut_key];
    if (bus.en && !done_m) begin
      if (bus.halt) done_m = 1;
      else if (bus.ret) begin
        if (stk_m.size() > 0) pc_m = stk_m.pop_back();
        else begin unf_m = 1; pc_m = pc_m + 16'd1; end
      end else if (bus.call) begin
        if (stk_m.size() < STACK_D) begin stk_m.push_back(pc_m + 16'd1); pc_m = a_rd; end
        else begin ovf_m = 1; pc_m = pc_m + 16'd1; end
      end else if (bus.br_abs) pc_m = a_rd;
      else if (bus.br_rel_z && flag_m) pc_m = pc_m + r_rd;
      else if (bus.br_rel_nz && !flag_m) pc_m = pc_m + r_rd;
      else pc_m = pc_m + 16'd1;
    end
    if (bus.flag_we) flag_m = bus.alu_zero;
    if (bus.lut_we) begin
      if (bus.lut_rel) rel_m[bus.lut_waddr] = bus.lut_wdata;
      else             abs_m[bus.lut_waddr] = bus.lut_wdata;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("pc", 32'(bus.pc), 32'(pc_m));
    check("done", 32'(bus.done), 32'(done_m));
    check("depth", 32'(bus.depth), 32'(stk_m.size()));
    check("err_ovf", 32'(bus.err_ovf), 32'(ovf_m));
    check("err_unf", 32'(bus.err_unf), 32'(unf_m));
  endtask

  task automatic idle();
    reset = 0;
    bus.en = 0; bus.br_abs = 0; bus.br_rel_z = 0; bus.br_rel_nz = 0;
    bus.call = 0; bus.ret = 0; bus.halt = 0; bus.lut_key = '0;
    bus.flag_we = 0; bus.alu_zero = 0; bus.lut_we = 0; bus.lut_rel = 0;
    bus.lut_waddr = '0; bus.lut_wdata = '0;
  endtask

  task automatic lut_write(input logic rel, input logic [4:0] addr, input logic [15:0] data);
    idle();
    bus.lut_we = 1; bus.lut_rel = rel; bus.lut_waddr = addr; bus.lut_wdata = data;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    idle();
    bus.en = 1;
    for (int i = 0; i < 3; i++) tick();
    check("count_pc", 32'(bus.pc), 32'h3);
    check("count_depth", 32'(bus.depth), 32'h0);

    // relative branches
    lut_write(1, 5'h03, 16'hFFFE);
    bus.en = 1; tick(); tick();
    check("at5", 32'(bus.pc), 32'h5);
    idle(); bus.flag_we = 1; bus.alu_zero = 1; tick();
    idle(); bus.en = 1; bus.br_rel_z = 1; bus.lut_key = 5'h03; tick();
    check("rel_z_taken", 32'(bus.pc), 32'h3);
    idle(); bus.en = 1; bus.br_rel_nz = 1; bus.lut_key = 5'h03; tick();
    check("rel_nz_not_taken", 32'(bus.pc), 32'h4);

    // call / ret
    lut_write(0, 5'h01, 16'h0010);
    lut_write(0, 5'h05, 16'h0040);
    bus.en = 1; bus.br_abs = 1; bus.lut_key = 5'h01; tick();
    check("abs_0x10", 32'(bus.pc), 32'h10);
    idle(); bus.en = 1; bus.call = 1; bus.lut_key = 5'h05; tick();
    check("call_pc", 32'(bus.pc), 32'h40);
    check("call_depth", 32'(bus.depth), 32'h1);
    idle(); bus.en = 1; bus.ret = 1; tick();
    check("ret_pc", 32'(bus.pc), 32'h11);
    check("ret_depth", 32'(bus.depth), 32'h0);

    // overflow / underflow
    idle(); bus.en = 1; bus.call = 1; bus.lut_key = 5'h05;
    for (int i = 0; i < 5; i++) tick();
    check("ovf_flag", 32'(bus.err_ovf), 32'h1);
    check("ovf_depth", 32'(bus.depth), 32'h4);
    check("ovf_pc", 32'(bus.pc), 32'h41);
    idle(); bus.en = 1; bus.ret = 1;
    for (int i = 0; i < 5; i++) tick();
    check("unf_flag", 32'(bus.err_unf), 32'h1);
    check("unf_pc", 32'(bus.pc), 32'h13);

    // wrap-around
    lut_write(0, 5'h02, 16'hFFFF);
    lut_write(0, 5'h04, 16'hFFFE);
    lut_write(1, 5'h06, 16'h0003);
    bus.en = 1; bus.br_abs = 1; bus.lut_key = 5'h02; tick();
    idle(); bus.en = 1; tick();
    check("wrap_inc", 32'(bus.pc), 32'h0);
    bus.br_abs = 1; bus.lut_key = 5'h04; tick();
    idle(); bus.en = 1; bus.br_rel_z = 1; bus.lut_key = 5'h06; tick();
    check("wrap_rel", 32'(bus.pc), 32'h1);

    // same-cycle LUT write and lookup sees old entry
    idle(); bus.en = 1; bus.br_abs = 1; bus.lut_key = 5'h01;
    bus.lut_we = 1; bus.lut_waddr = 5'h01; bus.lut_wdata = 16'h1234; tick();
    check("lut_old", 32'(bus.pc), 32'h10);

    // halt outranks branch and freezes
    lut_write(0, 5'h07, 16'h0007);
    bus.en = 1; bus.br_abs = 1; bus.lut_key = 5'h07; tick();
    idle(); bus.en = 1; bus.halt = 1; bus.br_abs = 1; bus.lut_key = 5'h01; tick();
    check("halt_done", 32'(bus.done), 32'h1);
    idle(); bus.en = 1;
    for (int i = 0; i < 10; i++) begin
      bus.call = 1'($urandom); bus.ret = 1'($urandom); bus.br_abs = 1'($urandom);
      tick();
    end
    check("halt_pc", 32'(bus.pc), 32'h7);

    // reset outranks a LUT write
    idle(); reset = 1; bus.lut_we = 1; bus.lut_waddr = 5'h07; bus.lut_wdata = 16'hBEEF; tick();
    check("rst2_pc", 32'(bus.pc), 32'h0);
    check("rst2_unf", 32'(bus.err_unf), 32'h0);
    idle(); bus.en = 1; bus.br_abs = 1; bus.lut_key = 5'h07; tick();
    check("rst_lut_clear", 32'(bus.pc), 32'h0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset         = ($urandom_range(0, 199) == 0);
      bus.en        = ($urandom_range(0, 9) < 8);
      bus.ret       = ($urandom_range(0, 99) < 8);
      bus.call      = ($urandom_range(0, 99) < 9);
      bus.br_abs    = ($urandom_range(0, 99) < 8);
      bus.br_rel_z  = ($urandom_range(0, 99) < 10);
      bus.br_rel_nz = ($urandom_range(0, 99) < 10);
      bus.halt      = ($urandom_range(0, 299) == 0);
      bus.lut_key   = 5'($urandom);
      bus.flag_we   = ($urandom_range(0, 9) < 3);
      bus.alu_zero  = 1'($urandom);
      bus.lut_we    = ($urandom_range(0, 9) < 3);
      bus.lut_rel   = 1'($urandom);
      bus.lut_waddr = 5'($urandom);
      bus.lut_wdata = 16'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the next-generation datapath. It owns the PC register, a run-time-writable bank of branch-target LUTs and a hardware call/return stack. It resolves absolute, relative, call and return control flow each cycle and drives the instruction ROM address and the DONE indication. It replaces the fixed-constant LUT and ad-hoc PC target selection used so far, so branch targets are loaded at START instead of being baked in at elaboration.

## Interface
Parameters:
- PC_W, 16: PC and LUT entry width.
- IDX_W, 4: LUT index bits per bank.
- BANK_W, 1: bank-select bits; number of banks is 2**BANK_W.
- STACK_D, 4: return-stack depth, at least 1.

Ports (name, direction, width, meaning):
- CLK, in, 1: the single clock; everything is rising-edge.
- reset, in, 1: synchronous, active-high reset.
- en, in, 1: advance enable; when low, PC and stack hold.
- br_abs, in, 1: branch to the ABS-LUT entry.
- br_rel_z, in, 1: relative branch if the zero flag is set.
- br_rel_nz, in, 1: relative branch if the zero flag is clear.
- call, in, 1: push PC+1, then jump to the ABS-LUT entry.
- ret, in, 1: pop the stack into PC.
- halt, in, 1: stop the sequencer.
- lut_key, in, IDX_W+BANK_W: bits [BANK_W-1:0] select the bank; the upper bits select the index.
- flag_we, in, 1: load the zero flag.
- alu_zero, in, 1: zero result from the ALU.
- lut_we, in, 1: write one LUT entry.
- lut_rel, in, 1: write target; 1 selects the REL LUT, 0 the ABS LUT.
- lut_waddr, in, IDX_W+BANK_W: write key, packed like lut_key.
- lut_wdata, in, PC_W: entry value; REL entries are two's complement.
- pc, out, PC_W: registered PC, driven to the instruction ROM.
- done, out, 1: registered, sticky halt indication.
- depth, out, clog2(STACK_D+1): current stack occupancy.
- err_ovf, out, 1: sticky, set by a call on a full stack.
- err_unf, out, 1: sticky, set by a ret on an empty stack.

## Operation
- State: pc, zero flag, return stack with occupancy counter, done, both error flags, and two LUT arrays (ABS and REL) of 2**(IDX_W+BANK_W) × PC_W each.
- Per cycle, when en=1 and done=0, next PC is chosen in this priority order:
  1. ret
  2. call
  3. br_abs
  4. br_rel_z when flag=1
  5. br_rel_nz when flag=0
  6. otherwise pc+1
- A lower-priority control asserted together with a higher one is ignored.
- Relative target: pc + REL[key] modulo 2**PC_W, so it wraps both ways. Absolute target: ABS[key].
- call, stack not full: push pc+1 modulo 2**PC_W, depth+1, pc ← ABS[key].
- call, stack full: no push, err_ovf←1, pc ← pc+1.
- ret, stack not empty: pc ← top of stack, depth−1.
- ret, stack empty: err_unf←1, pc ← pc+1.
- Branch conditions read the flag as registered before this edge. A flag_we in the same cycle affects only later cycles.
- The zero flag updates on flag_we regardless of en or done.
- LUT writes occur on any cycle with lut_we, including while en=0 or done=1. A lookup on the same cycle and same key returns the old entry.
- halt with en=1: done←1 at the edge and pc holds its current value. Afterwards all PC, stack and error updates freeze until reset. halt outranks every branch.
- en=0: pc, stack, depth and done hold. halt is ignored.

## Timing
- All outputs are registered; pc reflects control inputs after one edge. LUT read is combinational from lut_key into the next-PC logic.
- Reset values: pc=0, done=0, depth=0, err_ovf=0, err_unf=0, zero flag=0, all stack slots=0, all LUT entries=0.
- Reset takes priority over every other input in the same cycle, including lut_we. Asserting reset mid-program discards the stack and the errors.
- Back-to-back call/ret on consecutive cycles is supported with no bubble. Zero-cycle call-then-ret within one cycle is not possible because ret wins.

## Test plan
- Reset, then 3 cycles with en=1 and no controls: pc goes 0, 1, 2, 3; done=0; depth=0.
- Write REL[key=0x03]=−2 (0xFFFE). At pc=5, flag_we=1 with alu_zero=1; next cycle assert br_rel_z: pc=3. Repeat with br_rel_nz: pc=4, because the branch is not taken.
- Write ABS[key 0x05]=0x0040 (bank 1, idx 2). At pc=0x10, assert call: pc=0x0040, depth=1. Then assert ret: pc=0x0011, depth=0.
- STACK_D=4: perform 5 nested calls. The fifth sets err_ovf=1, depth stays 4, and pc becomes the old pc+1. Then perform 5 rets: the fifth sets err_unf.
- pc=0xFFFF with no control gives pc=0x0000. Relative branch with REL=+3 from pc=0xFFFE gives pc=0x0001.
- halt together with br_abs at pc=7: done=1 and pc stays 7 for 10 cycles. Pulse reset: pc=0, done=0, errors clear.
